cache_set_ctrl: RTL and testbench

Sequences one 4-way cache set built from cache_line instances, with one cache_line per way. It accepts single CPU byte requests, broadcasts lookups to all ways and selects the hit way. It picks the LRU/empty victim on a miss, fetches from memory through a req/ack handshake, and drives the per-way age pulses. Policy is write-through with write-allocate.

---
 rtl/cache_pkg.sv | 8 +
 rtl/cache_victim_sel.sv | 33 +++
 rtl/cache_set_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_set_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared defaults and controller state encoding for the 4-way cache set.
package cache_pkg;
    localparam int WAYS   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int AGE_W  = 2;
    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, UPDATE, MEM_WR, RESP} state_t;
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the hit way, else the lowest empty way, else the lowest oldest way.
module cache_victim_sel import cache_pkg::*; #(
    parameter int WAYS  = cache_pkg::WAYS,
    parameter int AGE_W = cache_pkg::AGE_W,
    localparam int IDX_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]       hit_i,
    input  logic [WAYS-1:0]       empty_i,
    input  logic [WAYS*AGE_W-1:0] age_i,
    output logic [IDX_W-1:0]      target_o,
    output logic                  hit_o
);
    logic [AGE_W-1:0] max_age;
    logic [IDX_W-1:0] hit_idx, empty_idx, old_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        max_age   = '0;
        hit_idx   = '0;
        empty_idx = '0;
        old_idx   = '0;
        for (int i = 0; i < WAYS; i++)
            if (age_i[i*AGE_W +: AGE_W] > max_age) max_age = age_i[i*AGE_W +: AGE_W];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_i[i]) hit_idx = IDX_W'(i);
            if (empty_i[i]) empty_idx = IDX_W'(i);
            if (age_i[i*AGE_W +: AGE_W] == max_age) old_idx = IDX_W'(i);
        end
    end

    assign hit_o    = |hit_i;
    assign target_o = hit_o ? hit_idx : (|empty_i ? empty_idx : old_idx);
endmodule

// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: write-through, write-allocate controller for one 4-way set.
// Optional CACHE_SET_STATS_EN adds saturating hit/miss counters.
module cache_set_ctrl import cache_pkg::*; #(
    parameter int WAYS   = cache_pkg::WAYS,
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int AGE_W  = cache_pkg::AGE_W,
    localparam int IDX_W = $clog2(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_hit,
    output logic                   line_ready,
    output logic [ADDR_W-1:0]      line_addr,
    output logic [DATA_W-1:0]      line_wdata,
    output logic [WAYS-1:0]        line_try_read,
    output logic [WAYS-1:0]        line_try_write,
    output logic [WAYS-1:0]        line_reset_age,
    output logic [WAYS-1:0]        line_inc_age,
    input  logic [WAYS*DATA_W-1:0] way_data,
    input  logic [WAYS*AGE_W-1:0]  way_age,
    input  logic [WAYS-1:0]        way_hit,
    input  logic [WAYS-1:0]        way_empty,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);
    localparam logic [AGE_W-1:0] MAX_AGE = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               write_q, hit_q;
    logic [IDX_W-1:0]   target_q, sel_target;
    logic               sel_hit;
    logic [AGE_W-1:0]   tgt_age;

    cache_victim_sel #(.WAYS(WAYS), .AGE_W(AGE_W)) u_sel (
        .hit_i(way_hit), .empty_i(way_empty), .age_i(way_age),
        .target_o(sel_target), .hit_o(sel_hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? LOOKUP : IDLE;
            LOOKUP:  state_d = (sel_hit || write_q) ? UPDATE : MEM_RD;
            MEM_RD:  state_d = mem_ack ? UPDATE : MEM_RD;
            UPDATE:  state_d = write_q ? MEM_WR : RESP;
            MEM_WR:  state_d = mem_ack ? RESP : MEM_WR;
            default: state_d = IDLE;
        endcase
    end

    // data_q holds write data, the filled line or the hit data, whichever the request needs.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            hit_q    <= 1'b0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                data_q  <= req_wdata;
            end
            if (state_q == LOOKUP) begin
                target_q <= sel_target;
                hit_q    <= sel_hit;
                if (sel_hit && !write_q) data_q <= way_data[sel_target*DATA_W +: DATA_W];
            end
            if (state_q == MEM_RD && mem_ack) data_q <= mem_rdata;
        end
    end

    assign req_ready      = state_q == IDLE;
    assign line_ready     = state_q != IDLE;
    assign line_addr      = addr_q;
    assign line_wdata     = data_q;
    assign line_try_read  = state_q == LOOKUP ? '1 : '0;
    assign line_try_write = (state_q == UPDATE && (write_q || !hit_q)) ? WAYS'(1) << target_q : '0;
    assign line_reset_age = state_q == UPDATE ? WAYS'(1) << target_q : '0;
    assign tgt_age        = way_age[target_q*AGE_W +: AGE_W];

    // Ages are stable between LOOKUP and UPDATE, so the live values are still the old ones.
    always_comb begin
        line_inc_age = '0;
        for (int i = 0; i < WAYS; i++)
            line_inc_age[i] = state_q == UPDATE && i != int'(target_q) && !way_empty[i]
                && way_age[i*AGE_W +: AGE_W] != MAX_AGE
                && (!hit_q || way_empty[target_q] || way_age[i*AGE_W +: AGE_W] < tgt_age);
    end

    assign mem_req    = state_q == MEM_RD || state_q == MEM_WR;
    assign mem_we     = state_q == MEM_WR;
    assign mem_addr   = addr_q;
    assign mem_wdata  = data_q;
    assign resp_valid = state_q == RESP;
    assign resp_data  = resp_valid ? data_q : '0;
    assign resp_hit   = resp_valid & hit_q;

`ifdef CACHE_SET_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (hit_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (!hit_q && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_set_ctrl.sv
// tb_cache_set_ctrl: scoreboard bench driving way status and a memory responder by hand.
module tb_cache_set_ctrl;
    logic        clk = 1'b0, rst_b = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        resp_valid, resp_hit, line_ready;
    logic [7:0]  resp_data, line_wdata, mem_wdata, mem_rdata = '0;
    logic [31:0] line_addr, mem_addr, way_data = '0;
    logic [3:0]  line_try_read, line_try_write, line_reset_age, line_inc_age;
    logic [7:0]  way_age = '0;
    logic [3:0]  way_hit = '0, way_empty = 4'hF;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [15:0] hit_count, miss_count;

    int n_cmp = 0, n_err = 0, exp_h = 0, exp_m = 0;
    logic [8:0] sb_q[$];
    logic [8:0] sb_e;

    cache_set_ctrl dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .line_ready(line_ready), .line_addr(line_addr), .line_wdata(line_wdata),
        .line_try_read(line_try_read), .line_try_write(line_try_write),
        .line_reset_age(line_reset_age), .line_inc_age(line_inc_age),
        .way_data(way_data), .way_age(way_age), .way_hit(way_hit), .way_empty(way_empty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (resp_valid) begin
        if (sb_q.size() == 0) check("unexp_resp", 1, 0);
        else begin
            sb_e = sb_q.pop_front();
            check("resp_data", 32'(resp_data), 32'(sb_e[7:0]));
            check("resp_hit", 32'(resp_hit), 32'(sb_e[8]));
            if (sb_e[8]) exp_h++; else exp_m++;
        end
    end

    task automatic set_ways(input logic [3:0] h, input logic [3:0] e, input logic [7:0] ages, input logic [31:0] d);
        way_hit = h; way_empty = e; way_age = ages; way_data = d;
    endtask

    task automatic run_req(input logic w, input logic [31:0] a, input logic [7:0] wd, input logic [7:0] md,
                           input int mdly, input logic [7:0] exp_d, input logic exp_hit,
                           input logic [3:0] exp_tw, input logic [3:0] exp_ra, input logic [3:0] exp_ia);
        logic [3:0] tw = '0, ra = '0, ia = '0;
        logic mreq = 1'b0, mwe = 1'b0, rv = 1'b0;
        logic [7:0] mwd = '0;
        logic [31:0] maddr = '0;
        int lat = 0, mcnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        check("req_ready", 32'(req_ready), 1);
        @(posedge clk);
        sb_q.push_back({exp_hit, exp_d});
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 40 && !rv; c++) begin
            tw |= line_try_write; ra |= line_reset_age; ia |= line_inc_age;
            if (mem_req) begin
                mreq = 1'b1; mwe = mem_we; mwd = mem_wdata; maddr = mem_addr;
                mcnt++;
                mem_ack = mcnt > mdly; mem_rdata = md;
            end else mem_ack = 1'b0;
            if (resp_valid) begin rv = 1'b1; lat = c; end
            else @(negedge clk);
        end
        mem_ack = 1'b0;
        if (!rv) check("timeout", 0, 1);
        check("try_write", 32'(tw), 32'(exp_tw));
        check("reset_age", 32'(ra), 32'(exp_ra));
        check("inc_age", 32'(ia), 32'(exp_ia));
        check("mem_req", 32'(mreq), 32'(w || !exp_hit));
        check("latency", lat, (!w && exp_hit) ? 3 : 4 + mdly);
        if (mreq) begin
            check("mem_we", 32'(mwe), 32'(w));
            check("mem_addr", maddr, a);
            if (w) check("mem_wdata", 32'(mwd), 32'(wd));
        end
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        check("back_idle", 32'(req_ready), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_resp", 32'(resp_valid), 0);
        check("rst_line_ready", 32'(line_ready), 0);
        check("rst_hit_cnt", 32'(hit_count), 0);
        check("rst_miss_cnt", 32'(miss_count), 0);
        rst_b = 1'b1;
        // cold read miss into empty set
        set_ways(4'b0000, 4'b1111, 8'h00, 32'h0);
        run_req(0, 32'h10, 8'h00, 8'h5A, 1, 8'h5A, 0, 4'b0001, 4'b0001, 4'b0000);
        // read hit way0
        set_ways(4'b0001, 4'b1110, 8'h00, 32'h0000_005A);
        run_req(0, 32'h10, 8'h00, 8'h00, 0, 8'h5A, 1, 4'b0000, 4'b0001, 4'b0000);
        // full set, LRU is way3
        set_ways(4'b0000, 4'b0000, 8'hE4, 32'h0);
        run_req(0, 32'h20, 8'h00, 8'h77, 0, 8'h77, 0, 4'b1000, 4'b1000, 4'b0111);
        // write hit way2 with slow memory
        set_ways(4'b0100, 4'b0000, 8'h1B, 32'h0);
        run_req(1, 32'h30, 8'hC3, 8'h00, 2, 8'hC3, 1, 4'b0100, 4'b0100, 4'b1000);
        // empty way1 chosen, max-age way0 not incremented
        set_ways(4'b0000, 4'b0010, 8'h93, 32'h0);
        run_req(0, 32'h40, 8'h00, 8'h11, 0, 8'h11, 0, 4'b0010, 4'b0010, 4'b1100);
        // multiple hits resolve to way1
        set_ways(4'b0110, 4'b0000, 8'hE4, 32'h0000_2200);
        run_req(0, 32'h50, 8'h00, 8'h00, 0, 8'h22, 1, 4'b0000, 4'b0010, 4'b0001);
        // age tie, lowest index wins
        set_ways(4'b0000, 4'b0000, 8'hAA, 32'h0);
        run_req(0, 32'h60, 8'h00, 8'h99, 0, 8'h99, 0, 4'b0001, 4'b0001, 4'b1110);
        // write miss allocates into empty way3
        set_ways(4'b0000, 4'b1000, 8'h24, 32'h0);
        run_req(1, 32'h70, 8'h3C, 8'h00, 0, 8'h3C, 0, 4'b1000, 4'b1000, 4'b0111);
        // reset while waiting in MEM_RD
        set_ways(4'b0000, 4'b1111, 8'h00, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_mreq", 32'(mem_req), 1);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        exp_h = 0; exp_m = 0;
        check("abort_mreq", 32'(mem_req), 0);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_resp", 32'(resp_valid), 0);
        repeat (6) @(negedge clk);
        check("abort_no_resp", 32'(resp_valid), 0);
        // counters after reset: two hits, one miss
        set_ways(4'b0001, 4'b1110, 8'h00, 32'h0000_005A);
        run_req(0, 32'h10, 8'h00, 8'h00, 0, 8'h5A, 1, 4'b0000, 4'b0001, 4'b0000);
        run_req(0, 32'h10, 8'h00, 8'h00, 0, 8'h5A, 1, 4'b0000, 4'b0001, 4'b0000);
        set_ways(4'b0000, 4'b1111, 8'h00, 32'h0);
        run_req(0, 32'h90, 8'h00, 8'h66, 0, 8'h66, 0, 4'b0001, 4'b0001, 4'b0000);
`ifdef CACHE_SET_STATS_EN
        check("hit_count", 32'(hit_count), exp_h);
        check("miss_count", 32'(miss_count), exp_m);
`else
        check("hit_count_off", 32'(hit_count), 0);
        check("miss_count_off", 32'(miss_count), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
